// File: rtl/param_cpu_if.sv
// Instruction-source and data-memory bus of param_cpu.
// master: the CPU core side; slave: the instruction source / memory side.
interface param_cpu_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          instr_valid;
    logic [15:0]   instr;
    logic          instr_ready;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    modport master (
        input  instr_valid, instr, mem_rdata, mem_ready,
        output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output instr_valid, instr, mem_rdata, mem_ready,
        input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/param_cpu.sv
// param_cpu: parametrised multicycle CPU core (IDLE/EXEC/WB/MEM/HALT).
// Instruction word: {op[15:12], rd[11:9], -, rs[7:5], -, imm[3:0]}.
// Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL(imm), 7 SHR(imm),
//          8 ADDI(zext imm), 9 LOAD, A STORE, B BRZ, C JMP, D MUL/illegal,
//          E illegal, F HALT.
// Optional feature macro: PARAM_CPU_MUL_EN turns opcode D into MUL;
// without it opcode D is illegal.
module param_cpu #(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int NREGS       = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    param_cpu_if.master    bus,
    output logic [AW-1:0]  pc,
    output logic           done,
    output logic           err,
    output logic [3:0]     flags
);
    localparam int RIW = (NREGS > 2) ? $clog2(NREGS) : 1;
    localparam int WW  = $clog2(MEM_TIMEOUT + 1);
    localparam int SW  = ((DW > AW) ? DW : AW) + 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LOAD = 4'h9;
    localparam logic [3:0] OP_STOR = 4'hA;
    localparam logic [3:0] OP_BRZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_WB   = 3'd2,
        S_MEM  = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [3:0]     r_op;
    logic [RIW-1:0] r_rd;
    logic [RIW-1:0] r_rs;
    logic [3:0]     r_imm;
    logic [DW-1:0]  r_regs [NREGS];

    logic [DW-1:0]  r_res;
    logic           r_c;
    logic           r_v;
    logic [AW-1:0]  r_pc;
    logic           r_done;
    logic           r_err;
    logic [3:0]     r_flags;
    logic [WW-1:0]  r_wait;

    logic           r_mem_req;
    logic           r_mem_we;
    logic [AW-1:0]  r_mem_addr;
    logic [DW-1:0]  r_mem_wdata;

    logic [DW-1:0]  w_a;
    logic [DW-1:0]  w_b;
    logic [DW-1:0]  w_zimm;
    logic [DW-1:0]  w_addb;
    logic [DW:0]    w_sum;
    logic [DW-1:0]  w_dif;
    logic [DW:0]    w_shl;
    logic [DW:0]    w_shr;
    logic [DW-1:0]  w_alu_res;
    logic           w_alu_c;
    logic           w_alu_v;
    logic           w_is_alu;
    logic           w_mul_op;
    logic           w_timeout;
    logic [AW-1:0]  w_simm;
    logic [AW-1:0]  w_pc_inc;
    logic [AW-1:0]  w_pc_br;

    // Operands are read from the register file in EXEC, before any write-back.
    assign w_a      = r_regs[r_rd];
    assign w_b      = r_regs[r_rs];
    assign w_zimm   = DW'(r_imm);
    assign w_addb   = (r_op == OP_ADDI) ? w_zimm : w_b;
    assign w_sum    = {1'b0, w_a} + {1'b0, w_addb};
    assign w_dif    = w_a - w_b;
    // Extra bit on the outgoing side captures the last bit shifted out.
    assign w_shl    = {1'b0, w_a} << r_imm;
    assign w_shr    = {w_a, 1'b0} >> r_imm;
    assign w_simm   = AW'($signed(r_imm));
    assign w_pc_inc = r_pc + AW'(1);
    assign w_pc_br  = r_pc + w_simm;
    assign w_timeout = (r_wait == WW'(MEM_TIMEOUT - 1));

`ifdef PARAM_CPU_MUL_EN
    logic [2*DW-1:0] w_prod;
    assign w_prod   = (2*DW)'(w_a) * (2*DW)'(w_b);
    assign w_mul_op = (r_op == OP_MUL);
`else
    assign w_mul_op = 1'b0;
`endif

    assign w_is_alu = ((r_op >= OP_ADD) && (r_op <= OP_ADDI)) || w_mul_op;

    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign pc              = r_pc;
    assign done            = r_done;
    assign err             = r_err;
    assign flags           = r_flags;

    // ALU: result plus carry/overflow for the current opcode.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (r_op)
            OP_ADD, OP_ADDI: begin
                w_alu_res = w_sum[DW-1:0];
                w_alu_c   = w_sum[DW];
                w_alu_v   = (w_a[DW-1] == w_addb[DW-1]) && (w_sum[DW-1] != w_a[DW-1]);
            end
            OP_SUB: begin
                w_alu_res = w_dif;
                w_alu_c   = (w_a < w_b);
                w_alu_v   = (w_a[DW-1] != w_b[DW-1]) && (w_dif[DW-1] != w_a[DW-1]);
            end
            OP_AND: w_alu_res = w_a & w_b;
            OP_OR:  w_alu_res = w_a | w_b;
            OP_XOR: w_alu_res = w_a ^ w_b;
            OP_SHL: begin
                w_alu_res = w_shl[DW-1:0];
                w_alu_c   = w_shl[DW];
            end
            OP_SHR: begin
                w_alu_res = w_shr[DW:1];
                w_alu_c   = w_shr[0];
            end
`ifdef PARAM_CPU_MUL_EN
            OP_MUL: begin
                w_alu_res = w_prod[DW-1:0];
                w_alu_c   = |w_prod[2*DW-1:DW];
            end
`endif
            default: begin
                w_alu_res = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid) w_next = S_EXEC;
                else                 w_next = S_IDLE;
            end
            S_EXEC: begin
                if (w_is_alu)                                    w_next = S_WB;
                else if ((r_op == OP_LOAD) || (r_op == OP_STOR)) w_next = S_MEM;
                else if (r_op == OP_HALT)                        w_next = S_HALT;
                else                                             w_next = S_IDLE;
            end
            S_WB: w_next = S_IDLE;
            S_MEM: begin
                if (bus.mem_ready || w_timeout) w_next = S_IDLE;
                else                            w_next = S_MEM;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: instruction latch, register file, PC, flags, memory request, sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= 4'h0;
            r_rd        <= '0;
            r_rs        <= '0;
            r_imm       <= 4'h0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_res       <= '0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_pc        <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_flags     <= 4'h0;
            r_wait      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        r_op  <= bus.instr[15:12];
                        r_rd  <= bus.instr[9 +: RIW];
                        r_rs  <= bus.instr[5 +: RIW];
                        r_imm <= bus.instr[3:0];
                    end
                end
                S_EXEC: begin
                    r_res  <= w_alu_res;
                    r_c    <= w_alu_c;
                    r_v    <= w_alu_v;
                    r_wait <= '0;
                    case (r_op)
                        OP_LOAD, OP_STOR: begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= (r_op == OP_STOR);
                            r_mem_addr  <= AW'(SW'(w_b) + SW'(r_imm));
                            r_mem_wdata <= w_a;
                        end
                        OP_BRZ:  r_pc   <= (w_b == '0) ? w_pc_br : w_pc_inc;
                        OP_JMP:  r_pc   <= w_pc_br;
                        OP_NOP:  r_pc   <= w_pc_inc;
                        OP_HALT: r_done <= 1'b1;
                        default: begin
                            // Everything not handled above and not an ALU op is illegal.
                            if (!w_is_alu) begin
                                r_err <= 1'b1;
                                r_pc  <= w_pc_inc;
                            end
                        end
                    endcase
                end
                S_WB: begin
                    r_regs[r_rd] <= r_res;
                    r_flags      <= {(r_res == '0), r_res[DW-1], r_c, r_v};
                    r_pc         <= w_pc_inc;
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (!r_mem_we) r_regs[r_rd] <= bus.mem_rdata;
                        r_pc      <= w_pc_inc;
                    end else if (w_timeout) begin
                        // Abort: the op still retires but the register file is untouched.
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_err     <= 1'b1;
                        r_pc      <= w_pc_inc;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_HALT: r_done <= 1'b1;
                default: r_done <= r_done;
            endcase
        end
    end
endmodule
